// File: rtl/alu_ctrl_issue_if.sv
// alu_ctrl_issue_if: ID-side op/operand handshake plus ALU-side head handshake for alu_ctrl_issue.
interface alu_ctrl_issue_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      alu_op;
   logic [2:0]      funct3;
   logic            funct7_b5;
   logic            is_rtype;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   modport master (output in_valid, alu_op, funct3, funct7_b5, is_rtype, op_a, op_b, out_ready,
                   input in_ready, out_valid, alu_control, alu_a, alu_b);
   modport slave  (input in_valid, alu_op, funct3, funct7_b5, is_rtype, op_a, op_b, out_ready,
                   output in_ready, out_valid, alu_control, alu_a, alu_b);
endinterface

// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue: decodes ALU control and issues it with operands through a 2-entry skid FIFO.
// Optional ALU_CTRL_ILLEGAL_TRAP_EN adds illegal_op / illegal_cnt.
module alu_ctrl_issue #(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   alu_ctrl_issue_if.slave  bus
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   ,
   output logic             illegal_op,
   output logic [7:0]       illegal_cnt
`endif
);
   logic [1:0]      occ_q, occ_d;
   logic            in_ready_q;
   logic [3:0]      ctl_d, hc_q, sc_q;
   logic [XLEN-1:0] ha_q, hb_q, sa_q, sb_q;
   logic            acc, pop, load_new, load_skid, skid_wr;

   always_comb begin
      ctl_d = bus.alu_op == 2'b00 ? 4'b0010 :
              bus.alu_op == 2'b01 ? 4'b0110 :
              bus.alu_op == 2'b11 ? 4'b1111 :
              bus.funct3 == 3'b000 ? ((bus.is_rtype & bus.funct7_b5) ? 4'b0110 : 4'b0010) :
              bus.funct3 == 3'b111 ? 4'b0000 :
              bus.funct3 == 3'b110 ? 4'b0001 : 4'b1111;
      // flush kills both the incoming beat and the pop
      acc       = bus.in_valid & in_ready_q & ~flush;
      pop       = (occ_q != 2'd0) & bus.out_ready & ~flush;
      load_new  = acc & ((occ_q == 2'd0) | pop);
      load_skid = pop & (occ_q == 2'd2);
      skid_wr   = acc & (occ_q == 2'd1) & ~pop;
      occ_d     = flush ? 2'd0 : occ_q + {1'b0, acc} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q      <= 2'd0;
         in_ready_q <= 1'b1;
         hc_q       <= 4'b0000;
         ha_q       <= '0;
         hb_q       <= '0;
      end else begin
         occ_q      <= occ_d;
         in_ready_q <= occ_d != 2'd2;
         if (load_new) begin
            hc_q <= ctl_d;
            ha_q <= bus.op_a;
            hb_q <= bus.op_b;
         end else if (load_skid) begin
            hc_q <= sc_q;
            ha_q <= sa_q;
            hb_q <= sb_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (skid_wr && !reset) begin
         sc_q <= ctl_d;
         sa_q <= bus.op_a;
         sb_q <= bus.op_b;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = occ_q != 2'd0;
   assign bus.alu_control = hc_q;
   assign bus.alu_a       = ha_q;
   assign bus.alu_b       = hb_q;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 8'd0;
      else if (pop && hc_q == 4'b1111 && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
   end

   assign illegal_op  = (occ_q != 2'd0) & (hc_q == 4'b1111);
   assign illegal_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue: directed + random stimulus checked against a queue-based reference model.
module tb_alu_ctrl_issue;
   typedef struct packed {
      logic [3:0]  c;
      logic [31:0] a;
      logic [31:0] b;
   } ent_t;

   logic clk = 1'b0;
   logic reset, flush;
   always #5 clk = ~clk;

   alu_ctrl_issue_if #(.XLEN(32)) bus ();
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic       illegal_op;
   logic [7:0] illegal_cnt;
`endif

   alu_ctrl_issue #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus)
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      , .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
`endif
   );

   int   errs = 0, checks = 0;
   ent_t q[$];
   int   mcnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] dec(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic rt);
      if (op == 2'd0) return 4'b0010;
      if (op == 2'd1) return 4'b0110;
      if (op == 2'd3) return 4'b1111;
      if (f3 == 3'd0) return (rt && f7) ? 4'b0110 : 4'b0010;
      if (f3 == 3'd7) return 4'b0000;
      if (f3 == 3'd6) return 4'b0001;
      return 4'b1111;
   endfunction

   task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic rt, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl, input logic rs);
      bus.in_valid = v; bus.alu_op = op; bus.funct3 = f3; bus.funct7_b5 = f7; bus.is_rtype = rt;
      bus.op_a = a; bus.op_b = b; bus.out_ready = ordy; flush = fl; reset = rs;
   endtask

   task automatic step();
      bit acc, pop;
      @(posedge clk);
      acc = bus.in_valid && q.size() < 2;
      pop = bus.out_ready && q.size() > 0;
      if (reset) begin
         q.delete();
         mcnt = 0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (pop) begin
            if (q[0].c == 4'b1111 && mcnt < 255) mcnt++;
            void'(q.pop_front());
         end
         if (acc) q.push_back('{dec(bus.alu_op, bus.funct3, bus.funct7_b5, bus.is_rtype), bus.op_a, bus.op_b});
      end
      @(negedge clk);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
         chk("alu_control", {28'd0, bus.alu_control}, {28'd0, q[0].c});
         chk("alu_a", bus.alu_a, q[0].a);
         chk("alu_b", bus.alu_b, q[0].b);
      end
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      chk("illegal_op", {31'd0, illegal_op}, {31'd0, q.size() > 0 && q[0].c == 4'b1111});
      chk("illegal_cnt", {24'd0, illegal_cnt}, mcnt);
`endif
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      chk("rst_ctl", {28'd0, bus.alu_control}, 32'd0);
      chk("rst_a", bus.alu_a, 32'd0);
      chk("rst_b", bus.alu_b, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

      drive(1, 2, 0, 1, 1, 7, 3, 1, 0, 0); step();
      chk("sub_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("sub_ctl", {28'd0, bus.alu_control}, 32'h6);
      chk("sub_a", bus.alu_a, 32'd7);
      chk("sub_b", bus.alu_b, 32'd3);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();

      drive(1, 2, 0, 0, 1, 11, 12, 0, 0, 0); step();
      drive(1, 2, 7, 0, 1, 21, 22, 0, 0, 0); step();
      chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
      drive(1, 2, 6, 0, 1, 31, 32, 0, 0, 0); step();
      chk("held_ctl", {28'd0, bus.alu_control}, 32'h2);
      drive(1, 2, 6, 0, 1, 31, 32, 1, 0, 0); step();
      chk("pop2_ctl", {28'd0, bus.alu_control}, 32'h0);
      step();
      chk("pop3_ctl", {28'd0, bus.alu_control}, 32'h1);
      chk("pop3_a", bus.alu_a, 32'd31);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
      chk("drained", {31'd0, bus.out_valid}, 32'd0);

      drive(1, 2, 0, 1, 0, 5, 6, 1, 0, 0); step();
      chk("addi_ctl", {28'd0, bus.alu_control}, 32'h2);
      drive(1, 2, 4, 0, 1, 5, 6, 1, 0, 0); step();
      chk("f3_100_ctl", {28'd0, bus.alu_control}, 32'hF);
      drive(1, 3, 0, 0, 0, 5, 6, 1, 0, 0); step();
      chk("op11_ctl", {28'd0, bus.alu_control}, 32'hF);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      chk("illegal_cnt2", {24'd0, illegal_cnt}, 32'd2);
`endif

      drive(1, 0, 0, 0, 0, 41, 42, 0, 0, 0); step(); step();
      drive(1, 1, 0, 0, 0, 51, 52, 0, 1, 0); step();
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_ready", {31'd0, bus.in_ready}, 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
      chk("flush_gone", {31'd0, bus.out_valid}, 32'd0);

      drive(1, 2, 7, 0, 0, 32'hDEAD, 32'hBEEF, 0, 0, 0); step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("mid_rst_ctl", {28'd0, bus.alu_control}, 32'd0);
      chk("mid_rst_a", bus.alu_a, 32'd0);
      chk("mid_rst_b", bus.alu_b, 32'd0);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      chk("mid_rst_cnt", {24'd0, illegal_cnt}, 32'd0);
`endif

      for (int i = 0; i < 3000; i++) begin
         drive($urandom % 4 != 0, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom, $urandom % 3 != 0, $urandom % 25 == 0, $urandom % 100 == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
